// File: rtl/pwm_width_meter.sv
// Measures the high time of each PWM channel after an arm request and then
// streams the per-channel widths out through a valid/ready handshake.
module pwm_width_meter #(
  parameter int STAGE   = 8,
  parameter int DWIDTH  = 8,
  parameter int CWIDTH  = DWIDTH + 1,
  parameter int TIMEOUT = 512
) (
  input  logic                     clkforcounter,
  input  logic                     rst,
  input  logic                     arm,
  input  logic [STAGE-1:0]         pwm_in,
  output logic                     busy,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(STAGE)-1:0] res_idx,
  output logic [CWIDTH-1:0]        res_width,
  output logic                     res_last,
  output logic                     done,
  output logic                     timeout,
  output logic [STAGE-1:0]         glitch
);

  localparam int IW = $clog2(STAGE);
  localparam int WW = $clog2(TIMEOUT) + 1;
  localparam logic [IW-1:0]     LAST = IW'(STAGE - 1);
  localparam logic [WW-1:0]     TMAX = WW'(TIMEOUT - 1);
  localparam logic [CWIDTH-1:0] CMAX = {CWIDTH{1'b1}};

  typedef enum logic [1:0] {IDLE, WAIT_RISE, MEASURE, DUMP} state_t;

  state_t            state;
  logic [CWIDTH-1:0] cnt     [STAGE];
  logic [CWIDTH-1:0] cnt_inc [STAGE];
  logic [STAGE-1:0]  prev;
  logic [STAGE-1:0]  rise_glitch;
  logic [WW-1:0]     wait_cnt;
  logic [IW-1:0]     nxt_idx;

  // Saturating per-channel increment and repeated-rise detection
  for (genvar gi = 0; gi < STAGE; gi++) begin : g_chan
    assign cnt_inc[gi] = (pwm_in[gi] && cnt[gi] != CMAX) ? cnt[gi] + 1'b1 : cnt[gi];
    assign rise_glitch[gi] = pwm_in[gi] && !prev[gi] && (cnt[gi] != '0);
  end

  assign nxt_idx = res_idx + 1'b1;

  always_ff @(posedge clkforcounter) begin
    if (!rst) begin
      state     <= IDLE;
      for (int i = 0; i < STAGE; i++) cnt[i] <= '0;
      prev      <= '0;
      wait_cnt  <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_idx   <= '0;
      res_width <= '0;
      res_last  <= 1'b0;
      done      <= 1'b0;
      timeout   <= 1'b0;
      glitch    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (arm) begin
            state    <= WAIT_RISE;
            busy     <= 1'b1;
            for (int i = 0; i < STAGE; i++) cnt[i] <= '0;
            prev     <= '0;
            wait_cnt <= '0;
            timeout  <= 1'b0;
            glitch   <= '0;
          end
        end
        WAIT_RISE: begin
          for (int i = 0; i < STAGE; i++) cnt[i] <= cnt_inc[i];
          prev <= pwm_in;
          if (|pwm_in) begin
            state <= MEASURE;
          end else if (wait_cnt == TMAX) begin
            // No channel ever rose: every counter is still zero
            state     <= DUMP;
            timeout   <= 1'b1;
            res_valid <= 1'b1;
            res_idx   <= '0;
            res_width <= cnt[0];
            res_last  <= 1'(STAGE == 1);
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        MEASURE: begin
          if (pwm_in == '0) begin
            state     <= DUMP;
            res_valid <= 1'b1;
            res_idx   <= '0;
            res_width <= cnt[0];
            res_last  <= 1'(STAGE == 1);
          end else begin
            for (int i = 0; i < STAGE; i++) cnt[i] <= cnt_inc[i];
            prev   <= pwm_in;
            glitch <= glitch | rise_glitch;
          end
        end
        DUMP: begin
          if (res_ready) begin
            if (res_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              res_valid <= 1'b0;
              res_last  <= 1'b0;
              done      <= 1'b1;
            end else begin
              res_idx   <= nxt_idx;
              res_width <= cnt[nxt_idx];
              res_last  <= (nxt_idx == LAST);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_pwm_width_meter.sv
// Directed bench for pwm_width_meter: table of width vectors plus hand-written
// stall, timeout, glitch and reset sequences.
module tb_pwm_width_meter;

  logic       clk = 1'b0;
  logic       rst;
  logic       arm;
  logic [7:0] pwm_in;
  logic       busy, res_valid, res_ready, res_last, done, timeout;
  logic [2:0] res_idx;
  logic [8:0] res_width;
  logic [7:0] glitch;

  int passed = 0;
  int total  = 0;

  typedef struct packed {
    logic [7:0][9:0] w;
    logic [7:0][8:0] e;
  } vec_t;

  vec_t vecs [3];

  pwm_width_meter dut (
    .clkforcounter(clk), .rst(rst), .arm(arm), .pwm_in(pwm_in), .busy(busy),
    .res_valid(res_valid), .res_ready(res_ready), .res_idx(res_idx),
    .res_width(res_width), .res_last(res_last), .done(done),
    .timeout(timeout), .glitch(glitch)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act == exp) passed++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic arm_it();
    @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    chk("busy_after_arm", busy, 1);
  endtask

  task automatic drive_widths(input logic [7:0][9:0] w);
    int mx = 0;
    for (int i = 0; i < 8; i++) if (int'(w[i]) > mx) mx = int'(w[i]);
    for (int t = 0; t < mx; t++) begin
      for (int i = 0; i < 8; i++) pwm_in[i] = (t < int'(w[i]));
      @(negedge clk);
    end
    pwm_in = '0;
  endtask

  // mode 0: ready always high; mode 1: stall 5 cycles on idx2, random elsewhere
  task automatic collect(input int mode, output logic [7:0][8:0] got);
    int hs = 0;
    int stall = 0;
    logic hold = 1'b0;
    logic [2:0] pi = '0;
    logic [8:0] pw = '0;
    logic r;
    got = '0;
    for (int cyc = 0; cyc < 300 && hs < 8; cyc++) begin
      @(negedge clk);
      if (cyc == 0) chk("first_valid_latency", res_valid, 1);
      if (hold) begin
        chk("stall_valid", res_valid, 1);
        chk("stall_idx", res_idx, pi);
        chk("stall_width", res_width, pw);
      end
      hold = 1'b0;
      if (mode == 0) r = 1'b1;
      else if (res_valid && res_idx == 3'd2 && stall < 5) begin
        r = 1'b0;
        stall++;
      end else r = 1'($urandom_range(0, 1));
      res_ready = r;
      if (res_valid) begin
        if (r) begin
          $display("handshake %0d: idx=%0d width=%0d last=%0d", hs, res_idx, res_width, res_last);
          chk("res_idx_order", res_idx, hs);
          chk("res_last", res_last, (hs == 7));
          got[res_idx] = res_width;
          hs++;
        end else begin
          hold = 1'b1;
          pi = res_idx;
          pw = res_width;
        end
      end
    end
    chk("handshake_count", hs, 8);
    if (mode == 1) chk("stall_cycles_on_idx2", stall, 5);
    @(negedge clk);
    res_ready = 1'b1;
    chk("done_pulse", done, 1);
    chk("valid_after_dump", res_valid, 0);
    chk("busy_after_dump", busy, 0);
    @(negedge clk);
    chk("done_one_cycle", done, 0);
  endtask

  task automatic check_widths(input string tag, input logic [7:0][8:0] got,
                              input logic [7:0][8:0] e);
    for (int i = 0; i < 8; i++) begin
      total++;
      if (got[i] == e[i]) passed++;
      else $display("FAIL %s width[%0d]: got %0d expected %0d", tag, i, got[i], e[i]);
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int mode);
    logic [7:0][8:0] got;
    arm_it();
    drive_widths(v.w);
    collect(mode, got);
    check_widths(tag, got, v.e);
    chk({tag, "_glitch"}, glitch, 0);
    chk({tag, "_timeout"}, timeout, 0);
  endtask

  initial begin
    logic [7:0][8:0] got;
    logic [7:0][8:0] zeros;
    logic [7:0] p;

    // widths (i+1)*16
    for (int i = 0; i < 8; i++) begin
      vecs[0].w[i] = 10'((i + 1) * 16);
      vecs[0].e[i] = 9'((i + 1) * 16);
    end
    vecs[1].w = {10'd2, 10'd128, 10'd7, 10'd0, 10'd3, 10'd255, 10'd1, 10'd0};
    vecs[1].e = {9'd2, 9'd128, 9'd7, 9'd0, 9'd3, 9'd255, 9'd1, 9'd0};
    // ch0 held 600 cycles saturates at 511
    vecs[2].w = {10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd0, 10'd5, 10'd600};
    vecs[2].e = {9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd0, 9'd5, 9'd511};
    zeros = '0;

    rst = 1'b0; arm = 1'b0; pwm_in = '0; res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", res_valid, 0);
    chk("rst_idx", res_idx, 0);
    chk("rst_width", res_width, 0);
    chk("rst_last", res_last, 0);
    chk("rst_done", done, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_glitch", glitch, 0);
    rst = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 3; k++) run_vec($sformatf("vec%0d", k), vecs[k], 0);

    // backpressure
    run_vec("stall", vecs[0], 1);

    // timeout: 512 WAIT_RISE cycles with no rise
    arm_it();
    repeat (511) @(negedge clk);
    chk("timeout_not_yet", timeout, 0);
    chk("valid_not_yet", res_valid, 0);
    collect(0, got);
    check_widths("timeout", got, zeros);
    chk("timeout_flag", timeout, 1);
    chk("timeout_glitch", glitch, 0);

    // ch3 high 4, low 2, high 5; others high 12 cycles
    arm_it();
    for (int t = 0; t < 12; t++) begin
      p = 8'hFF;
      if ((t >= 4 && t < 6) || t >= 11) p[3] = 1'b0;
      pwm_in = p;
      @(negedge clk);
    end
    pwm_in = '0;
    collect(0, got);
    check_widths("glitch_run", got, {9'd12, 9'd12, 9'd12, 9'd12, 9'd9, 9'd12, 9'd12, 9'd12});
    chk("glitch_flags", glitch, 8'h08);
    chk("glitch_timeout", timeout, 0);

    // reset mid-measurement
    arm_it();
    pwm_in = 8'hFF;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    pwm_in = '0;
    chk("midrst_busy", busy, 0);
    chk("midrst_valid", res_valid, 0);
    repeat (4) @(negedge clk);
    chk("midrst_valid_later", res_valid, 0);
    chk("midrst_busy_later", busy, 0);
    run_vec("rearm", vecs[0], 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: got stuck expected finish");
    $fatal(1, "bench time limit");
  end

endmodule
